// File: rtl/wb_grf.sv
// wb_grf: writeback stage and general register file of the five-stage pipeline.
// Selects and extends the W-stage writeback value, commits it into a 32x32
// register file, and serves two decode read ports with same-cycle bypass.
// A committed-write counter and last-write trace support debug.
//
// Ports:
//   clk, reset (async, active-low)
//   RegWriteW, WriteRegW, MemtoRegW, opcodeW, pcW, ALUoutW, DMoutW,
//   ALU_2outW, CP0_outW, PrRDW, HitDMW   - W-stage inputs from M/W register
//   A1, A2 / RD1, RD2                     - decode read ports (bypassed)
//   WD_W                                  - final writeback value
//   wb_count, wb_last_pc, wb_last_reg, wb_last_data - commit trace
module wb_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [2:0]  MemtoRegW,
  input  logic [5:0]  opcodeW,
  input  logic [31:0] pcW,
  input  logic [31:0] ALUoutW,
  input  logic [31:0] DMoutW,
  input  logic [31:0] ALU_2outW,
  input  logic [31:0] CP0_outW,
  input  logic [31:0] PrRDW,
  input  logic        HitDMW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic [31:0] wb_count,
  output logic [31:0] wb_last_pc,
  output logic [4:0]  wb_last_reg,
  output logic [31:0] wb_last_data
);

  logic [31:0] rf_r [32];
  logic [31:0] wb_count_r;
  logic [31:0] last_pc_r;
  logic [4:0]  last_reg_r;
  logic [31:0] last_data_r;

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_s;
  logic [31:0] wd_s;
  logic        commit_s;

  // Byte/halfword lane select; the halfword lane ignores ALUoutW[0].
  always_comb begin
    byte_s = 8'd0;
    case (ALUoutW[1:0])
      2'd0:    byte_s = DMoutW[7:0];
      2'd1:    byte_s = DMoutW[15:8];
      2'd2:    byte_s = DMoutW[23:16];
      2'd3:    byte_s = DMoutW[31:24];
      default: byte_s = 8'd0;
    endcase
    if (ALUoutW[1]) begin
      half_s = DMoutW[31:16];
    end else begin
      half_s = DMoutW[15:0];
    end
  end

  // Load extension by opcode; bridge reads bypass extension entirely.
  always_comb begin
    load_s = DMoutW;
    if (HitDMW) begin
      case (opcodeW)
        6'h23:   load_s = DMoutW;
        6'h20:   load_s = {{24{byte_s[7]}}, byte_s};
        6'h24:   load_s = {24'd0, byte_s};
        6'h21:   load_s = {{16{half_s[15]}}, half_s};
        6'h25:   load_s = {16'd0, half_s};
        default: load_s = DMoutW;
      endcase
    end else begin
      load_s = PrRDW;
    end
  end

  // Writeback source mux.
  always_comb begin
    wd_s = 32'd0;
    case (MemtoRegW)
      3'd0:    wd_s = ALUoutW;
      3'd1:    wd_s = load_s;
      3'd2:    wd_s = pcW + 32'd8;
      3'd3:    wd_s = ALU_2outW;
      3'd4:    wd_s = CP0_outW;
      default: wd_s = 32'd0;
    endcase
  end

  assign commit_s = RegWriteW & (WriteRegW != 5'd0);
  assign WD_W     = wd_s;

  // Read port 1 with same-cycle bypass; stays live during reset.
  always_comb begin
    RD1 = 32'd0;
    if (A1 == 5'd0) begin
      RD1 = 32'd0;
    end else if (commit_s && (A1 == WriteRegW)) begin
      RD1 = wd_s;
    end else begin
      RD1 = rf_r[A1];
    end
  end

  // Read port 2 with same-cycle bypass; stays live during reset.
  always_comb begin
    RD2 = 32'd0;
    if (A2 == 5'd0) begin
      RD2 = 32'd0;
    end else if (commit_s && (A2 == WriteRegW)) begin
      RD2 = wd_s;
    end else begin
      RD2 = rf_r[A2];
    end
  end

  // Register file and trace state; $0 is never written so it stays 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
      wb_count_r  <= 32'd0;
      last_pc_r   <= 32'd0;
      last_reg_r  <= 5'd0;
      last_data_r <= 32'd0;
    end else if (commit_s) begin
      rf_r[WriteRegW] <= wd_s;
      wb_count_r      <= wb_count_r + 32'd1;
      last_pc_r       <= pcW;
      last_reg_r      <= WriteRegW;
      last_data_r     <= wd_s;
    end
  end

  assign wb_count     = wb_count_r;
  assign wb_last_pc   = last_pc_r;
  assign wb_last_reg  = last_reg_r;
  assign wb_last_data = last_data_r;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: behavioural register-file model, a per-cycle
// compare of every output, directed literal cases and a randomized run.
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [2:0]  MemtoRegW;
  logic [5:0]  opcodeW;
  logic [31:0] pcW, ALUoutW, DMoutW, ALU_2outW, CP0_outW, PrRDW;
  logic        HitDMW;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, WD_W, wb_count, wb_last_pc, wb_last_data;
  logic [4:0]  wb_last_reg;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_count, m_pc, m_data;
  logic [4:0]  m_reg;

  wb_grf dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .MemtoRegW(MemtoRegW), .opcodeW(opcodeW), .pcW(pcW), .ALUoutW(ALUoutW),
    .DMoutW(DMoutW), .ALU_2outW(ALU_2outW), .CP0_outW(CP0_outW), .PrRDW(PrRDW),
    .HitDMW(HitDMW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W),
    .wb_count(wb_count), .wb_last_pc(wb_last_pc), .wb_last_reg(wb_last_reg),
    .wb_last_data(wb_last_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_wd();
    int unsigned off;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    off = ALUoutW[1:0];
    b = 8'(DMoutW >> (8 * off));
    h = 16'(DMoutW >> (16 * (off / 2)));
    if (!HitDMW) ld = PrRDW;
    else if (opcodeW == 6'h20) ld = 32'($signed(b));
    else if (opcodeW == 6'h24) ld = 32'(b);
    else if (opcodeW == 6'h21) ld = 32'($signed(h));
    else if (opcodeW == 6'h25) ld = 32'(h);
    else ld = DMoutW;
    if (MemtoRegW == 3'd0) return ALUoutW;
    if (MemtoRegW == 3'd1) return ld;
    if (MemtoRegW == 3'd2) return pcW + 32'd8;
    if (MemtoRegW == 3'd3) return ALU_2outW;
    if (MemtoRegW == 3'd4) return CP0_outW;
    return 32'd0;
  endfunction

  function automatic logic model_commit();
    return RegWriteW && (WriteRegW != 5'd0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (model_commit() && a == WriteRegW) return model_wd();
    return m_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_count = 32'd0; m_pc = 32'd0; m_reg = 5'd0; m_data = 32'd0;
  endtask

  // Compare every output against the model, settled away from the clock edge.
  task automatic settle_check();
    if (!reset) model_clear();
    #1;
    chk("WD_W", WD_W, model_wd());
    chk("RD1", RD1, model_rd(A1));
    chk("RD2", RD2, model_rd(A2));
    chk("wb_count", wb_count, m_count);
    chk("wb_last_pc", wb_last_pc, m_pc);
    chk("wb_last_reg", {27'd0, wb_last_reg}, {27'd0, m_reg});
    chk("wb_last_data", wb_last_data, m_data);
  endtask

  task automatic advance();
    logic [31:0] wd;
    wd = model_wd();
    @(posedge clk);
    if (reset && model_commit()) begin
      m_rf[WriteRegW] = wd;
      m_count = m_count + 32'd1;
      m_pc = pcW; m_reg = WriteRegW; m_data = wd;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    RegWriteW = 1'b0; WriteRegW = 5'd0; MemtoRegW = 3'd0; opcodeW = 6'h23;
    pcW = 32'd0; ALUoutW = 32'd0; DMoutW = 32'd0; ALU_2outW = 32'd0;
    CP0_outW = 32'd0; PrRDW = 32'd0; HitDMW = 1'b1; A1 = 5'd0; A2 = 5'd0;
  endtask

  task automatic do_load(input string name, input logic [5:0] op, input logic [1:0] off,
                         input logic [31:0] exp);
    RegWriteW = 1'b0; MemtoRegW = 3'd1; HitDMW = 1'b1; DMoutW = 32'h80FF7F01;
    opcodeW = op; ALUoutW = {30'h00001000, off};
    settle_check();
    chk(name, WD_W, exp);
    advance();
  endtask

  initial begin
    logic [31:0] cnt_before;
    idle_inputs();
    reset = 1'b0;
    model_clear();

    // Reset: writes requested during reset must not land, bypass still live.
    RegWriteW = 1'b1; WriteRegW = 5'd3; ALUoutW = 32'hDEADBEEF; A1 = 5'd3; A2 = 5'd4;
    settle_check();
    chk("rst_bypass_rd1", RD1, 32'hDEADBEEF);
    advance();
    RegWriteW = 1'b0;
    settle_check();
    chk("rst_rd1_zero", RD1, 32'd0);
    chk("rst_count_zero", wb_count, 32'd0);
    advance();
    reset = 1'b1;
    settle_check();
    chk("rel_count_zero", wb_count, 32'd0);
    advance();

    // Word write with bypass
    RegWriteW = 1'b1; WriteRegW = 5'd5; MemtoRegW = 3'd0; ALUoutW = 32'h12345678;
    A1 = 5'd5; A2 = 5'd5; pcW = 32'h00003000;
    settle_check();
    chk("bypass_rd1", RD1, 32'h12345678);
    chk("bypass_rd2", RD2, 32'h12345678);
    advance();
    RegWriteW = 1'b0; ALUoutW = 32'd0;
    settle_check();
    chk("stored_rd1", RD1, 32'h12345678);
    chk("count_1", wb_count, 32'd1);
    chk("last_reg_5", {27'd0, wb_last_reg}, 32'd5);
    advance();

    // Byte and halfword loads
    do_load("lb_off3", 6'h20, 2'd3, 32'hFFFFFF80);
    do_load("lbu_off3", 6'h24, 2'd3, 32'h00000080);
    do_load("lh_off0", 6'h21, 2'd0, 32'h00007F01);
    do_load("lhu_off2", 6'h25, 2'd2, 32'h000080FF);
    do_load("lh_off1", 6'h21, 2'd1, 32'h00007F01);
    do_load("lw_off0", 6'h23, 2'd0, 32'h80FF7F01);

    // Bridge load ignores extension
    HitDMW = 1'b0; PrRDW = 32'hCAFEBABE; opcodeW = 6'h20; MemtoRegW = 3'd1;
    settle_check();
    chk("bridge_lb", WD_W, 32'hCAFEBABE);
    advance();

    // Write to $0 is dropped
    cnt_before = wb_count;
    RegWriteW = 1'b1; WriteRegW = 5'd0; A1 = 5'd0;
    settle_check();
    chk("r0_bypass", RD1, 32'd0);
    advance();
    RegWriteW = 1'b0;
    settle_check();
    chk("r0_count", wb_count, cnt_before);
    advance();

    // Link and HI/LO
    HitDMW = 1'b1; MemtoRegW = 3'd2; pcW = 32'h00003000;
    settle_check();
    chk("link", WD_W, 32'h00003008);
    advance();
    MemtoRegW = 3'd3; ALU_2outW = 32'h0BADF00D;
    settle_check();
    chk("hilo", WD_W, 32'h0BADF00D);
    advance();
    MemtoRegW = 3'd2; pcW = 32'hFFFFFFFC;
    settle_check();
    chk("link_wrap", WD_W, 32'h00000004);
    advance();

    // Bubble with live pcW changes nothing
    cnt_before = wb_count;
    RegWriteW = 1'b0; WriteRegW = 5'd5; MemtoRegW = 3'd0; ALUoutW = 32'h55555555;
    pcW = 32'h00004000; A1 = 5'd5;
    settle_check();
    advance();
    settle_check();
    chk("bubble_rd1", RD1, 32'h12345678);
    chk("bubble_count", wb_count, cnt_before);
    advance();

    // Randomized run with occasional mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      RegWriteW = ($urandom_range(0, 3) != 0);
      WriteRegW = 5'($urandom_range(0, 9));
      MemtoRegW = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: opcodeW = 6'h23;
        1: opcodeW = 6'h20;
        2: opcodeW = 6'h24;
        3: opcodeW = 6'h21;
        4: opcodeW = 6'h25;
        default: opcodeW = 6'($urandom);
      endcase
      pcW = $urandom; ALUoutW = $urandom; DMoutW = $urandom; ALU_2outW = $urandom;
      CP0_outW = $urandom; PrRDW = $urandom; HitDMW = 1'($urandom);
      A1 = ($urandom_range(0, 2) == 0) ? WriteRegW : 5'($urandom_range(0, 9));
      A2 = ($urandom_range(0, 2) == 0) ? WriteRegW : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 199) != 0);
      settle_check();
      advance();
    end
    reset = 1'b1;

    // Counter wrap: preload the counter to all-ones, then commit once
    idle_inputs();
    force dut.wb_count_r = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_r;
    m_count = 32'hFFFFFFFF;
    settle_check();
    chk("preload", wb_count, 32'hFFFFFFFF);
    RegWriteW = 1'b1; WriteRegW = 5'd7; ALUoutW = 32'h00000077;
    advance();
    RegWriteW = 1'b0;
    settle_check();
    chk("wrap_zero", wb_count, 32'd0);
    chk("wrap_last_data", wb_last_data, 32'h00000077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
